// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared mode constants, step encoding and quadrature decode for the encoder channel
package enc_pkg;

    localparam logic [1:0] ENC_MODE_X4 = 2'd0;
    localparam logic [1:0] ENC_MODE_X2 = 2'd1;
    localparam logic [1:0] ENC_MODE_X1 = 2'd2;

    typedef logic signed [1:0] enc_step_t;

    localparam enc_step_t ENC_STEP_FWD  = 2'sb01;
    localparam enc_step_t ENC_STEP_NONE = 2'sb00;
    localparam enc_step_t ENC_STEP_REV  = 2'sb11;

    // AB is packed {A,B}; forward order is 00->01->11->10->00, jumps of both bits give no step
    function automatic enc_step_t enc_decode(input logic [1:0] prev_ab,
                                             input logic [1:0] cur_ab,
                                             input logic [1:0] mode);
        logic fwd;
        logic rev;
        logic a_chg;
        fwd = (prev_ab == 2'b00 && cur_ab == 2'b01) || (prev_ab == 2'b01 && cur_ab == 2'b11) ||
              (prev_ab == 2'b11 && cur_ab == 2'b10) || (prev_ab == 2'b10 && cur_ab == 2'b00);
        rev = (prev_ab == 2'b01 && cur_ab == 2'b00) || (prev_ab == 2'b11 && cur_ab == 2'b01) ||
              (prev_ab == 2'b10 && cur_ab == 2'b11) || (prev_ab == 2'b00 && cur_ab == 2'b10);
        a_chg = prev_ab[1] ^ cur_ab[1];
        enc_decode = ENC_STEP_NONE;
        case (mode)
            ENC_MODE_X2: begin
                if (a_chg && fwd) enc_decode = ENC_STEP_FWD;
                else if (a_chg && rev) enc_decode = ENC_STEP_REV;
            end
            ENC_MODE_X1: begin
                if (prev_ab == 2'b01 && cur_ab == 2'b11) enc_decode = ENC_STEP_FWD;
                else if (prev_ab == 2'b11 && cur_ab == 2'b01) enc_decode = ENC_STEP_REV;
            end
            default: begin
                if (fwd) enc_decode = ENC_STEP_FWD;
                else if (rev) enc_decode = ENC_STEP_REV;
            end
        endcase
    endfunction

endpackage

// File: rtl/enc_input_filter.sv
// rtl/enc_input_filter.sv - 2-FF synchroniser plus stability filter for one asynchronous input bit
module enc_input_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    if (FILTER_LEN == 0) begin : g_bypass
        assign dout = sync2_q;
    end else begin : g_filter
        localparam int CNT_W = $clog2(FILTER_LEN + 1);

        logic             filt_q, filt_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // cnt_q holds how many consecutive cycles the synced bit has differed from the output
        always_comb begin
            filt_d = filt_q;
            cnt_d  = '0;
            if (sync2_q != filt_q) begin
                if (cnt_q == CNT_W'(FILTER_LEN - 1)) filt_d = sync2_q;
                else cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                filt_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                filt_q <= filt_d;
                cnt_q  <= cnt_d;
            end
        end

        assign dout = filt_q;
    end

endmodule

// File: rtl/quad_encoder_channel.sv
// rtl/quad_encoder_channel.sv - quadrature encoder channel; velocity window built only with ENC_VELOCITY_EN
module quad_encoder_channel
    import enc_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int FILTER_LEN    = 4,
    parameter int WINDOW_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             enc_z,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             err_clear,
    output logic [WIDTH-1:0] position,
    output logic             direction,
    output logic [WIDTH-1:0] index_pos,
    output logic             index_valid,
    output logic             err,
    output logic [WIDTH-1:0] velocity,
    output logic             velocity_valid
);

    if (WINDOW_CYCLES < 2) begin : g_window_check
        $error("WINDOW_CYCLES must be at least 2");
    end

    logic a_f, b_f, z_f;

    enc_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (.clk(clk), .reset(reset), .din(enc_a), .dout(a_f));
    enc_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (.clk(clk), .reset(reset), .din(enc_b), .dout(b_f));
    enc_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_z (.clk(clk), .reset(reset), .din(enc_z), .dout(z_f));

    logic [1:0]       prev_ab_q, prev_ab_d;
    logic             z_prev_q, z_prev_d;
    logic [WIDTH-1:0] position_q, position_d;
    logic             direction_q, direction_d;
    logic [WIDTH-1:0] index_pos_q, index_pos_d;
    logic             index_valid_q, index_valid_d;
    logic             err_q, err_d;
    enc_step_t        step;
    logic [WIDTH-1:0] step_ext;
    logic             illegal;

    always_comb begin
        step          = enc_decode(prev_ab_q, {a_f, b_f}, mode);
        step_ext      = WIDTH'(step);
        illegal       = (prev_ab_q ^ {a_f, b_f}) == 2'b11;
        prev_ab_d     = {a_f, b_f};
        z_prev_d      = z_f;
        position_d    = position_q;
        direction_d   = direction_q;
        if (load) begin
            position_d = load_value;
        end else if (enable) begin
            position_d = position_q + step_ext;
            if (step != ENC_STEP_NONE) direction_d = (step == ENC_STEP_FWD);
        end
        // index captures the value position takes this cycle, independent of enable
        index_pos_d   = index_pos_q;
        index_valid_d = 1'b0;
        if (z_f && !z_prev_q) begin
            index_pos_d   = position_d;
            index_valid_d = 1'b1;
        end
        err_d = illegal | (err_q & ~err_clear);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_ab_q     <= 2'b00;
            z_prev_q      <= 1'b0;
            position_q    <= '0;
            direction_q   <= 1'b0;
            index_pos_q   <= '0;
            index_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            prev_ab_q     <= prev_ab_d;
            z_prev_q      <= z_prev_d;
            position_q    <= position_d;
            direction_q   <= direction_d;
            index_pos_q   <= index_pos_d;
            index_valid_q <= index_valid_d;
            err_q         <= err_d;
        end
    end

    assign position    = position_q;
    assign direction   = direction_q;
    assign index_pos   = index_pos_q;
    assign index_valid = index_valid_q;
    assign err         = err_q;

`ifdef ENC_VELOCITY_EN
    localparam int WIN_W = $clog2(WINDOW_CYCLES);

    logic [WIN_W-1:0] win_q, win_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] velocity_q, velocity_d;
    logic             velocity_valid_q, velocity_valid_d;
    logic [WIDTH-1:0] counted;

    // accumulator follows counted steps only, so a preload does not disturb the rate
    always_comb begin
        counted          = enable ? step_ext : '0;
        velocity_d       = velocity_q;
        velocity_valid_d = 1'b0;
        if (win_q == WIN_W'(WINDOW_CYCLES - 1)) begin
            win_d            = '0;
            acc_d            = '0;
            velocity_d       = acc_q + counted;
            velocity_valid_d = 1'b1;
        end else begin
            win_d = win_q + WIN_W'(1);
            acc_d = acc_q + counted;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            win_q            <= '0;
            acc_q            <= '0;
            velocity_q       <= '0;
            velocity_valid_q <= 1'b0;
        end else begin
            win_q            <= win_d;
            acc_q            <= acc_d;
            velocity_q       <= velocity_d;
            velocity_valid_q <= velocity_valid_d;
        end
    end

    assign velocity       = velocity_q;
    assign velocity_valid = velocity_valid_q;
`else
    assign velocity       = '0;
    assign velocity_valid = 1'b0;
`endif

endmodule

// File: tb/tb_quad_encoder_channel.sv
// tb/tb_quad_encoder_channel.sv - scoreboard bench for quad_encoder_channel (WIDTH=8, FILTER_LEN=4)
module tb_quad_encoder_channel;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset, enable, enc_a, enc_b, enc_z, load, err_clear;
    logic [1:0]       mode;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] position, index_pos, velocity;
    logic             direction, index_valid, err, velocity_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] idx_q[$];
    logic [WIDTH-1:0] vel_q[$];

    always #5 clk = ~clk;

    quad_encoder_channel #(.WIDTH(WIDTH), .FILTER_LEN(4), .WINDOW_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .enable(enable), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
        .mode(mode), .load(load), .load_value(load_value), .err_clear(err_clear),
        .position(position), .direction(direction), .index_pos(index_pos), .index_valid(index_valid),
        .err(err), .velocity(velocity), .velocity_valid(velocity_valid)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_ab(input logic [1:0] ab, input int hold);
        enc_a = ab[1];
        enc_b = ab[0];
        tick(hold);
    endtask

    task automatic pulse_load(input logic [WIDTH-1:0] v);
        load = 1'b1;
        load_value = v;
        tick(1);
        load = 1'b0;
    endtask

    task automatic pulse_err_clear();
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (position !== 8'd0) begin
            n_fail++; $display("FAIL reset_position: got %0h expected 0", position);
        end
        n_checks++;
        if ({direction, index_pos, index_valid, err, velocity, velocity_valid} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got dir=%b idx=%0h iv=%b err=%b vel=%0h vv=%b expected all 0",
                               direction, index_pos, index_valid, err, velocity, velocity_valid);
        end
    endtask

    task automatic test_x4_forward();
        logic [1:0]       seq [3] = '{2'b11, 2'b10, 2'b00};
        logic [WIDTH-1:0] exp_pos = 8'd1;
        logic [WIDTH-1:0] got, exp;
        mode  = 2'd0;
        enc_b = 1'b1;
        tick(6);
        n_checks++;
        if (position !== 8'd0) begin
            n_fail++; $display("FAIL x4_latency_early: got %0d expected 0", position);
        end
        tick(1);
        n_checks++;
        if (position !== 8'd1) begin
            n_fail++; $display("FAIL x4_latency_7: got %0d expected 1", position);
        end
        tick(3);
        for (int i = 0; i < 3; i++) begin
            exp_pos = exp_pos + 8'd1;
            exp_q.push_back(exp_pos);
            drive_ab(seq[i], 10);
            got = position;
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++; $display("FAIL x4_fwd_pos[%0d]: got %0d expected %0d", i, got, exp);
            end
        end
        n_checks++;
        if (direction !== 1'b1) begin
            n_fail++; $display("FAIL x4_fwd_dir: got %b expected 1", direction);
        end
    endtask

    task automatic test_x2_reverse();
        logic [1:0]       seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
        logic [WIDTH-1:0] dlt [4] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        logic [WIDTH-1:0] exp_pos = 8'd0;
        logic [WIDTH-1:0] got, exp;
        pulse_load(8'd0);
        n_checks++;
        if (position !== 8'd0 || direction !== 1'b1) begin
            n_fail++; $display("FAIL load_keeps_dir: got pos=%0d dir=%b expected pos=0 dir=1", position, direction);
        end
        mode = 2'd1;
        for (int i = 0; i < 4; i++) begin
            exp_pos = exp_pos + dlt[i];
            exp_q.push_back(exp_pos);
            drive_ab(seq[i], 10);
            got = position;
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++; $display("FAIL x2_rev_pos[%0d]: got %0h expected %0h", i, got, exp);
            end
        end
        n_checks++;
        if (position !== 8'hFE || direction !== 1'b0) begin
            n_fail++; $display("FAIL x2_rev_final: got pos=%0h dir=%b expected pos=fe dir=0", position, direction);
        end
    endtask

    task automatic test_x1_reverse();
        logic [1:0]       seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
        logic [WIDTH-1:0] dlt [4] = '{8'h00, 8'h00, 8'hFF, 8'h00};
        logic [WIDTH-1:0] exp_pos = 8'd0;
        logic [WIDTH-1:0] got, exp;
        pulse_load(8'd0);
        mode = 2'd2;
        for (int i = 0; i < 4; i++) begin
            exp_pos = exp_pos + dlt[i];
            exp_q.push_back(exp_pos);
            drive_ab(seq[i], 10);
            got = position;
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++; $display("FAIL x1_rev_pos[%0d]: got %0h expected %0h", i, got, exp);
            end
        end
        n_checks++;
        if (position !== 8'hFF || direction !== 1'b0) begin
            n_fail++; $display("FAIL x1_rev_final: got pos=%0h dir=%b expected pos=ff dir=0", position, direction);
        end
    endtask

    task automatic test_glitch_illegal();
        mode  = 2'd0;
        enc_a = 1'b1;
        tick(3);
        enc_a = 1'b0;
        tick(12);
        n_checks++;
        if (position !== 8'hFF || err !== 1'b0) begin
            n_fail++; $display("FAIL glitch: got pos=%0h err=%b expected pos=ff err=0", position, err);
        end
        drive_ab(2'b11, 10);
        n_checks++;
        if (position !== 8'hFF || err !== 1'b1) begin
            n_fail++; $display("FAIL illegal_jump: got pos=%0h err=%b expected pos=ff err=1", position, err);
        end
        drive_ab(2'b00, 10);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky: got %b expected 1", err);
        end
        pulse_err_clear();
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL err_clear: got %b expected 0", err);
        end
    endtask

    task automatic test_wrap_index();
        int pulses = 0;
        pulse_load(8'd127);
        n_checks++;
        if (position !== 8'd127) begin
            n_fail++; $display("FAIL load_127: got %0d expected 127", position);
        end
        exp_q.push_back(8'h80);
        drive_ab(2'b01, 10);
        n_checks++;
        if (position !== exp_q.pop_front()) begin
            n_fail++; $display("FAIL wrap: got %0h expected 80", position);
        end
        pulse_load(8'd5);
        idx_q.push_back(8'd6);
        enc_z = 1'b1;
        enc_a = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (index_valid === 1'b1) begin
                pulses++;
                n_checks++;
                if (idx_q.size() == 0) begin
                    n_fail++; $display("FAIL index_extra: got index_valid=1 expected 0");
                end else if (index_pos !== idx_q[0]) begin
                    n_fail++; $display("FAIL index_pos: got %0d expected %0d", index_pos, idx_q[0]);
                end
                if (idx_q.size() != 0) void'(idx_q.pop_front());
            end
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++; $display("FAIL index_pulse_width: got %0d cycles expected 1", pulses);
        end
        n_checks++;
        if (position !== 8'd6) begin
            n_fail++; $display("FAIL index_step_pos: got %0d expected 6", position);
        end
        enc_z = 1'b0;
        tick(10);
    endtask

    task automatic test_reset_mid();
        pulse_load(8'd37);
        n_checks++;
        if (position !== 8'd37) begin
            n_fail++; $display("FAIL load_37: got %0d expected 37", position);
        end
        enc_z = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        n_checks++;
        if ({position, direction, index_pos, index_valid, err, velocity, velocity_valid} !== '0) begin
            n_fail++; $display("FAIL reset_mid: got pos=%0d dir=%b idx=%0d iv=%b err=%b expected all 0",
                               position, direction, index_pos, index_valid, err);
        end
        tick(12);
        n_checks++;
        if (err !== 1'b1 || position !== 8'd0) begin
            n_fail++; $display("FAIL reset_held_11: got err=%b pos=%0d expected err=1 pos=0", err, position);
        end
        enc_z = 1'b0;
        drive_ab(2'b00, 12);
        pulse_err_clear();
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_clear: got %b expected 0", err);
        end
    endtask

    task automatic test_enable_low();
        int pulses = 0;
        pulse_load(8'd20);
        enable = 1'b0;
        drive_ab(2'b01, 10);
        n_checks++;
        if (position !== 8'd20) begin
            n_fail++; $display("FAIL enable_low_hold: got %0d expected 20", position);
        end
        idx_q.push_back(8'd20);
        enc_z = 1'b1;
        enc_a = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (index_valid === 1'b1) begin
                pulses++;
                n_checks++;
                if (idx_q.size() == 0) begin
                    n_fail++; $display("FAIL enable_low_index_extra: got index_valid=1 expected 0");
                end else if (index_pos !== idx_q[0]) begin
                    n_fail++; $display("FAIL enable_low_index_pos: got %0d expected %0d", index_pos, idx_q[0]);
                end
                if (idx_q.size() != 0) void'(idx_q.pop_front());
            end
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++; $display("FAIL enable_low_index_pulse: got %0d expected 1", pulses);
        end
        enc_z = 1'b0;
        drive_ab(2'b10, 10);
        drive_ab(2'b00, 10);
        n_checks++;
        if (position !== 8'd20 || direction !== 1'b0) begin
            n_fail++; $display("FAIL enable_low_final: got pos=%0d dir=%b expected pos=20 dir=0", position, direction);
        end
        enable = 1'b1;
    endtask

    task automatic test_velocity();
        logic [1:0] seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        int  pulses   = 0;
        int  exp_puls = 0;
        logic nonzero = 1'b0;
        mode  = 2'd0;
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
`ifdef ENC_VELOCITY_EN
        vel_q.push_back(8'd10);
        exp_puls = 1;
`endif
        fork
            begin
                for (int i = 0; i < 10; i++) drive_ab(seq[i % 4], 8);
            end
            begin
                for (int k = 0; k < 110; k++) begin
                    tick(1);
                    if (velocity !== 8'd0) nonzero = 1'b1;
                    if (velocity_valid === 1'b1) begin
                        pulses++;
                        n_checks++;
                        if (vel_q.size() == 0) begin
                            n_fail++; $display("FAIL velocity_extra: got velocity_valid=1 expected 0");
                        end else if (velocity !== vel_q[0]) begin
                            n_fail++; $display("FAIL velocity_value: got %0d expected %0d", velocity, vel_q[0]);
                        end
                        if (vel_q.size() != 0) void'(vel_q.pop_front());
                    end
                end
            end
        join
        n_checks++;
        if (pulses != exp_puls) begin
            n_fail++; $display("FAIL velocity_pulses: got %0d expected %0d", pulses, exp_puls);
        end
        n_checks++;
        if (position !== 8'd10) begin
            n_fail++; $display("FAIL velocity_pos: got %0d expected 10", position);
        end
`ifndef ENC_VELOCITY_EN
        n_checks++;
        if (nonzero !== 1'b0) begin
            n_fail++; $display("FAIL velocity_tied: got nonzero velocity expected 0");
        end
`endif
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; enc_a = 1'b0; enc_b = 1'b0; enc_z = 1'b0;
        mode = 2'd0; load = 1'b0; load_value = '0; err_clear = 1'b0;
        tick(3);
        test_reset();
        reset = 1'b1;
        tick(2);
        test_x4_forward();
        test_x2_reverse();
        test_x1_reverse();
        test_glitch_illegal();
        test_wrap_index();
        test_reset_mid();
        test_enable_low();
        test_velocity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/quad_encoder_channel.md
Name: quad_encoder_channel

Overview:
- Parametrised quadrature-encoder channel; successor to the team's fixed 32-bit x4 decoder.
- Adds input synchronisation and a glitch filter, selectable x1/x2/x4 counting, position preload, index (Z) capture and illegal-transition detection.
- One instance per motor axis, with outputs feeding the register-map block.

Parameters:
- WIDTH, 32, position/index/velocity width (two's complement).
- FILTER_LEN, 4, consecutive stable cycles required before a synced input is accepted; 0 = filter bypassed.
- WINDOW_CYCLES, 100000, velocity sample window in clk cycles (only used with ENC_VELOCITY_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge).
- enable  in  1  counting enable; the input pipeline keeps running when low.
- enc_a  in  1  raw quadrature A, asynchronous.
- enc_b  in  1  raw quadrature B, asynchronous.
- enc_z  in  1  raw index pulse, asynchronous.
- mode  in  2  0=x4, 1=x2, 2=x1, 3=x4 (reserved alias).
- load  in  1  one-cycle preload strobe.
- load_value  in  WIDTH  preload value.
- err_clear  in  1  clears err.
- position  out  WIDTH  signed count.
- direction  out  1  1=forward, 0=reverse; last non-zero step.
- index_pos  out  WIDTH  position captured at the index rising edge.
- index_valid  out  1  one-cycle pulse when index_pos updates.
- err  out  1  sticky illegal-transition flag.
- velocity  out  WIDTH  signed counts per window.
- velocity_valid  out  1  one-cycle pulse per window.

Behaviour:
- Reset values: position=0, direction=0, index_pos=0, index_valid=0, err=0, velocity=0, velocity_valid=0. Sync/filter state = 0, filtered AB = 00, filtered Z = 0.
- Input path (A, B and Z each):
  - 2-FF synchroniser, then filter.
  - The filtered value takes the synced value once it has been identical for FILTER_LEN consecutive cycles.
  - Latency: raw edge to position change = 3+FILTER_LEN cycles (3 when FILTER_LEN=0).
  - Pulses shorter than FILTER_LEN cycles never propagate.
- Decode: compare registered prev filtered AB ({A,B}) with current filtered AB.
  - Forward sequence: 00->01->11->10->00.
  - x4: every legal transition counts ±1.
  - x2: only A-changing transitions count: 01->11 and 10->00 give +1; 11->01 and 00->10 give -1.
  - x1: only 01->11 (+1) and 11->01 (-1) count.
  - Illegal transitions (00<->11, 01<->10): step 0, err<=1 in every mode, regardless of enable.
- Position update priority, per cycle:
  - load: position<=load_value; step discarded; direction unchanged.
  - else, enable high: position<=position+step.
  - else: hold.
  - Wraps modulo 2^WIDTH; no saturation.
  - direction updates only on non-zero counted steps while enable is high.
- Mode change takes effect on the next decode; it never alters position by itself.
- Index:
  - A filtered-Z rising edge sets index_pos to the value position takes in that same cycle: load_value if load, else position+step.
  - index_valid pulses for exactly one cycle.
  - Capture happens even when enable is low.
- err: set by illegal transitions, cleared by err_clear. If both occur in the same cycle, set wins.
- Reset mid-operation: all state, including the synchroniser and filter, returns to reset values in one cycle. The first post-reset decode compares against AB=00, so an input held at 11 through reset produces err=1 once it propagates.

Optional Feature:
- Macro: ENC_VELOCITY_EN.
- Defined:
  - A free-running window counter counts 0..WINDOW_CYCLES-1.
  - An accumulator sums the counted steps; load does not affect it.
  - At wrap: velocity<=accumulator total including the current step, velocity_valid pulses one cycle, accumulator restarts at 0.
- Undefined: velocity and velocity_valid are tied to 0; no window or accumulator logic is present.

Decomposition:
- Package enc_pkg:
  - Mode constants ENC_MODE_X4=0, ENC_MODE_X2=1, ENC_MODE_X1=2.
  - Step encoding: signed 2-bit values +1/0/-1.
- Sub-module enc_input_filter (parameter FILTER_LEN): synchroniser plus stability filter for one bit, instantiated three times.

Test Plan:
- FILTER_LEN=4, x4: one full forward cycle 00,01,11,10,00 with each state held 10 cycles -> position=4, direction=1. The first change appears 7 cycles after the enc_b edge.
- Same sequence reversed in x2, then in x1 -> position=-2 (x2), -1 (x1), direction=0.
- 3-cycle glitch on enc_a, and 00->11 applied in a single cycle -> glitch ignored (position unchanged, err=0); the jump gives err=1, no count. err_clear gives err=0.
- WIDTH=8, load with load_value=127, then one forward x4 step -> position=-128 (wrap). A Z rise coincident with a step from 5 -> index_pos=6, index_valid high for 1 cycle.
- Drive reset=0 mid-sequence with position=37 -> next cycle all outputs at reset values. enable=0 with steps -> position holds, but Z still captures.
- ENC_VELOCITY_EN, WINDOW_CYCLES=100, 10 forward x4 steps inside a window -> velocity=10 with one velocity_valid pulse at the window end. Without the macro -> velocity=0 always.
